// File: rtl/multdiv_sched_if.sv
// Request/response bundle between decode and the shared multiply/divide sequencer.
// The master side (decode) issues start pulses and operands; the slave side
// (the sequencer) returns the stall request, the result and the writeback.
interface multdiv_sched_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [4:0]       dest_reg;
    logic             stall;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             wb_en;
    logic [4:0]       wb_reg;
    logic [WIDTH-1:0] wb_data;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, dest_reg,
        input  stall, data_result, data_exception, data_resultRDY, wb_en, wb_reg, wb_data
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, dest_reg,
        output stall, data_result, data_exception, data_resultRDY, wb_en, wb_reg, wb_data
    );
endinterface

// File: rtl/multdiv_sched.sv
// Sequencer for the shared iterative multiply/divide unit.
// Accepts one mult or div, runs WIDTH radix-2 steps on operand magnitudes while
// holding the pipeline, then issues exactly one writeback in a one-cycle DONE state.
// Divide by zero skips the iterations and completes on the next edge.
// Build option: MULTDIV_STATUS_WB_EN -- when defined, an exception writes the
// status code (4 = mul, 5 = div) to STATUS_REG instead of the destination register.
module multdiv_sched #(
    parameter int WIDTH      = 32,
    parameter int STATUS_REG = 30
) (
    input  logic           clock,
    input  logic           reset,
    multdiv_sched_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Control state
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_div_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic [4:0]       dest_q;

    // Datapath: hi_q is the upper product half / partial remainder,
    // lo_q the multiplier being consumed / dividend being shifted into quotient,
    // opnd_q the multiplicand / divisor magnitude.
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;

    // Registered outputs
    logic             rdy_q;
    logic             exc_q;
    logic [WIDTH-1:0] result_q;
    logic             wb_en_q;
    logic [4:0]       wb_reg_q;
    logic [WIDTH-1:0] wb_data_q;

    // Start decode
    logic             can_accept;
    logic             start_div;
    logic             accept;
    logic             div_by_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Iteration and completion values
    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     r_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic               neg;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_exc;
    logic [4:0]         fin_wb_reg;
    logic [WIDTH-1:0]   fin_wb_data;
    logic [4:0]         dbz_wb_reg;
    logic [WIDTH-1:0]   dbz_wb_data;

    // Start acceptance: only outside BUSY, MULT wins when both pulses arrive together
    always_comb begin
        can_accept  = (state_q != BUSY);
        start_div   = bus.ctrl_DIV & ~bus.ctrl_MULT;
        accept      = can_accept & (bus.ctrl_MULT | bus.ctrl_DIV);
        div_by_zero = start_div & (bus.data_operandB == '0);
        a_mag       = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
        b_mag       = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
    end

    // One shift-add or restoring-division step, and the sign-corrected result it yields when it is the last
    always_comb begin
        // NOTE: every signal written here gets a value on all paths first, so no latch is inferred.
        mult_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        r_shift  = {hi_q, lo_q[WIDTH-1]};
        div_ge   = (r_shift >= {1'b0, opnd_q});
        step_hi  = mult_sum[WIDTH:1];
        step_lo  = {mult_sum[0], lo_q[WIDTH-1:1]};
        if (is_div_q) begin
            step_hi = div_ge ? WIDTH'(r_shift - {1'b0, opnd_q}) : r_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end

        neg  = sign_a_q ^ sign_b_q;
        prod = neg ? -{step_hi, step_lo} : {step_hi, step_lo};
        quot = neg ? -step_lo : step_lo;

        if (is_div_q) begin
            // A positive quotient with the top bit set only arises from -2^(WIDTH-1) / -1
            fin_res = quot;
            fin_exc = ~neg & step_lo[WIDTH-1];
        end else begin
            // Overflow when the upper half is not the sign extension of bit WIDTH-1
            fin_res = prod[WIDTH-1:0];
            fin_exc = (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}});
        end

`ifdef MULTDIV_STATUS_WB_EN
        fin_wb_reg  = fin_exc ? 5'(STATUS_REG) : dest_q;
        fin_wb_data = fin_exc ? (is_div_q ? WIDTH'(5) : WIDTH'(4)) : fin_res;
        dbz_wb_reg  = 5'(STATUS_REG);
        dbz_wb_data = WIDTH'(5);
`else
        fin_wb_reg  = dest_q;
        fin_wb_data = fin_res;
        dbz_wb_reg  = bus.dest_reg;
        dbz_wb_data = '0;
`endif
    end

    // Main FSM: sequencing, datapath registers and registered writeback outputs
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            dest_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            rdy_q     <= 1'b0;
            exc_q     <= 1'b0;
            result_q  <= '0;
            wb_en_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
        end else begin
            // Outputs live for the single DONE cycle only
            rdy_q     <= 1'b0;
            exc_q     <= 1'b0;
            result_q  <= '0;
            wb_en_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;

            case (state_q)
                BUSY: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q   <= DONE;
                        cnt_q     <= '0;
                        rdy_q     <= 1'b1;
                        wb_en_q   <= 1'b1;
                        exc_q     <= fin_exc;
                        result_q  <= fin_res;
                        wb_reg_q  <= fin_wb_reg;
                        wb_data_q <= fin_wb_data;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    if (accept) begin
                        is_div_q <= start_div;
                        sign_a_q <= bus.data_operandA[WIDTH-1];
                        sign_b_q <= bus.data_operandB[WIDTH-1];
                        dest_q   <= bus.dest_reg;
                        cnt_q    <= '0;
                        hi_q     <= '0;
                        lo_q     <= start_div ? a_mag : b_mag;
                        opnd_q   <= start_div ? b_mag : a_mag;
                        if (div_by_zero) begin
                            state_q   <= DONE;
                            rdy_q     <= 1'b1;
                            wb_en_q   <= 1'b1;
                            exc_q     <= 1'b1;
                            result_q  <= '0;
                            wb_reg_q  <= dbz_wb_reg;
                            wb_data_q <= dbz_wb_data;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.stall          = (state_q == BUSY) | accept;
    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.wb_en          = wb_en_q;
    assign bus.wb_reg         = wb_reg_q;
    assign bus.wb_data        = wb_data_q;
endmodule

// File: tb/tb_multdiv_sched.sv
// Scoreboard bench for multdiv_sched: the driver computes each accepted
// operation's expected writeback from signed arithmetic and queues it; the
// monitor checks stall, idle-zero outputs and every completion independently.
module tb_multdiv_sched;
    localparam int WIDTH      = 32;
    localparam int STATUS_REG = 30;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        int          due;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multdiv_sched_if #(.WIDTH(WIDTH)) bus ();

    multdiv_sched #(.WIDTH(WIDTH), .STATUS_REG(STATUS_REG)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   done_cyc = 0;
    bit   mon_en   = 1'b0;
    exp_t exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers
    function automatic exp_t model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] dest);
        exp_t   e;
        longint sa, sb, r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        e.due = 0;
        if (!is_div) begin
            r     = sa * sb;
            e.res = r[31:0];
            e.exc = (r[63:31] != {33{r[31]}});
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            r     = sa / sb;
            e.res = r[31:0];
            e.exc = 1'b0;
        end
`ifdef MULTDIV_STATUS_WB_EN
        e.wreg  = e.exc ? 5'(STATUS_REG) : dest;
        e.wdata = e.exc ? (is_div ? 32'd5 : 32'd4) : e.res;
`else
        e.wreg  = dest;
        e.wdata = e.res;
`endif
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drive one start pulse; if the controller is free, queue its expected writeback
    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest);
        exp_t e;
        bit   is_div;
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.dest_reg      = dest;
        if ((m || d) && cyc >= done_cyc) begin
            is_div   = !m;
            e        = model(is_div, a, b, dest);
            e.due    = cyc + ((is_div && b == 32'd0) ? 1 : 33);
            done_cyc = e.due;
            exp_q.push_back(e);
        end
        tick(1);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        bus.dest_reg      = 5'($urandom);
    endtask

    task automatic wait_done();
        if (done_cyc > cyc) tick(done_cyc - cyc);
        tick(1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        done_cyc = 0;
    endtask

    function automatic logic [31:0] rand_opnd();
        logic [31:0] specials [5];
        specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, 40)) - 32'd20;
            1:       return specials[$urandom_range(0, 4)];
            2:       return 32'($signed(16'($urandom)));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: stall every cycle, zero outputs outside completion, scoreboard on completion
    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            check("stall", 64'(bus.stall), 64'(cyc < done_cyc));
            if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                check("missing_rdy", 64'(cyc), 64'(exp_q[0].due));
                void'(exp_q.pop_front());
            end
            if (bus.data_resultRDY === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rdy", 64'(bus.data_resultRDY), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rdy_cycle", 64'(cyc), 64'(e.due));
                    check("data_result", 64'(bus.data_result), 64'(e.res));
                    check("data_exception", 64'(bus.data_exception), 64'(e.exc));
                    check("wb_en", 64'(bus.wb_en), 64'd1);
                    check("wb_reg", 64'(bus.wb_reg), 64'(e.wreg));
                    check("wb_data", 64'(bus.wb_data), 64'(e.wdata));
                end
            end else begin
                check("idle_outputs",
                      {bus.data_resultRDY, bus.data_exception, bus.wb_en, bus.wb_reg,
                       bus.data_result, bus.wb_data} , 64'd0);
            end
        end
    end

    initial begin
        bit m, d;
        logic [31:0] a, b;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.dest_reg      = '0;

        reset = 1'b1;
        tick(2);
        mon_en = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);

        // Signed multiply and multiply overflow
        issue(1, 0, 32'd7, -32'sd6, 5'd5);
        wait_done();
        issue(1, 0, 32'h0001_0000, 32'h0001_0000, 5'd9);
        wait_done();

        // Divide, the -2^31 / -1 case issued in the DONE cycle, and divide by zero
        issue(0, 1, 32'd100, -32'sd7, 5'd11);
        tick(done_cyc - cyc);
        issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        wait_done();
        issue(0, 1, 32'd9, 32'd0, 5'd3);
        wait_done();

        // Ignored start while busy, back-to-back start in DONE, dest r0, both pulses high
        issue(1, 0, 32'd3, 32'd4, 5'd7);
        tick(4);
        issue(0, 1, 32'd50, 32'd5, 5'd8);
        tick(done_cyc - cyc);
        issue(1, 1, 32'd5, 32'd6, 5'd0);
        wait_done();

        // Reset in the middle of a multiply discards it
        issue(1, 0, 32'h1234, 32'h77, 5'd4);
        tick(9);
        pulse_reset();
        tick(40);
        issue(1, 0, 32'd2, 32'd2, 5'd6);
        wait_done();

        // Randomized traffic with varied issue timing
        for (int i = 0; i < 40; i++) begin
            int mode;
            int op;
            mode = $urandom_range(0, 2);
            op   = $urandom_range(0, 3);
            m    = (op == 0) || (op == 2);
            d    = (op != 0);
            a    = rand_opnd();
            b    = (op == 3 && $urandom_range(0, 1) == 1) ? 32'd0 : rand_opnd();
            if (mode == 2 && cyc + 1 < done_cyc) begin
                issue(1, 0, $urandom, $urandom, 5'($urandom));
            end
            if (mode == 0) begin
                if (done_cyc > cyc) tick(done_cyc - cyc);
            end else begin
                wait_done();
                tick($urandom_range(0, 2));
            end
            issue(m, d, a, b, 5'($urandom));
        end
        wait_done();

        for (int k = 0; k < 100 && exp_q.size() > 0; k++) tick(1);
        check("drain", 64'(exp_q.size()), 64'd0);
        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
